uc_fsm: RTL and testbench

- Sequential control unit for the `microc` single-cycle datapath.
- Consumes `Opcode` and the `z` flag from `microc`.
- Drives `microc`'s control inputs (`s_inc`, `s_inm`, `we3`, `wez`, `Op`) and a new PC load enable (`pc_we`).
- Adds start/halt/single-step sequencing, illegal-opcode trapping and a retired-instruction counter for debug.

---
 rtl/uc_fsm.sv | 169 ++++++++++++++++
 tb/tb_uc_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_fsm.sv
// Sequential control unit for the microc single-cycle datapath: start/halt/single-step
// sequencing, combinational instruction decode, illegal-opcode trap and retired-instruction counter.
module uc_fsm #(
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  HALT_OP = 6'b010011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q;

    logic             exec;
    logic             trap;
    logic             is_halt, is_illegal;
    logic             dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_pc_we;
    logic [2:0]       dec_op;

    // Reset gates exec directly so every enable drops the moment reset goes low.
    assign exec = reset && ((state_q == S_RUN) ||
                            ((state_q == S_STEP) && step && !step_q));
    assign trap = exec && (is_halt || is_illegal);

    always_comb begin
        dec_s_inc  = 1'b0;
        dec_s_inm  = 1'b0;
        dec_we3    = 1'b0;
        dec_wez    = 1'b0;
        dec_op     = 3'b000;
        dec_pc_we  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (Opcode == HALT_OP) begin
            is_halt = 1'b1;
        end else begin
            casez (Opcode)
                6'b1?????: begin
                    dec_s_inc = 1'b1;
                    dec_we3   = 1'b1;
                    dec_wez   = 1'b1;
                    dec_op    = Opcode[4:2];
                    dec_pc_we = 1'b1;
                end
                6'b000000: begin
                    dec_s_inc = 1'b1;
                    dec_pc_we = 1'b1;
                end
                6'b0001??: begin
                    dec_s_inc = 1'b1;
                    dec_s_inm = 1'b1;
                    dec_we3   = 1'b1;
                    dec_pc_we = 1'b1;
                end
                6'b010000: begin
                    dec_pc_we = 1'b1;
                end
                6'b010001: begin
                    dec_s_inc = ~z;
                    dec_pc_we = 1'b1;
                end
                6'b010010: begin
                    dec_s_inc = z;
                    dec_pc_we = 1'b1;
                end
                default: begin
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        s_inc = 1'b0;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        pc_we = 1'b0;
        if (exec) begin
            s_inc = dec_s_inc;
            s_inm = dec_s_inm;
            we3   = dec_we3;
            wez   = dec_wez;
            Op    = dec_op;
            pc_we = dec_pc_we;
        end
    end

    // A trap outranks any step_mode change in the same cycle.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = step_mode ? S_STEP : S_RUN;
            end
            S_RUN: begin
                if (trap) begin
                    state_d   = S_HALT;
                    illegal_d = illegal_q | is_illegal;
                end else if (step_mode) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (trap) begin
                    state_d   = S_HALT;
                    illegal_d = illegal_q | is_illegal;
                end else if (!step_mode) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc_we && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            step_q    <= step;
        end
    end

    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_fsm.sv
// Randomized and directed bench for uc_fsm: a reference model pushes expected outputs into a
// queue, a negedge monitor pops and compares; a second instance with a 2-bit counter checks saturation.
module tb_uc_fsm;

    localparam logic [5:0] HALT_OP = 6'b010011;
    localparam logic [5:0] OP_ALU1 = 6'b100100;
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LI   = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_BAD  = 6'b001010;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [5:0]  Opcode;
    logic        z, start, step_mode, step;
    logic        s_inc, s_inm, we3, wez, pc_we, halted, illegal;
    logic [2:0]  Op;
    logic [15:0] instr_count;
    logic        s_inc_s, s_inm_s, we3_s, wez_s, pc_we_s, halted_s, illegal_s;
    logic [2:0]  Op_s;
    logic [1:0]  instr_count_s;

    uc_fsm #(.CNT_W(16), .HALT_OP(HALT_OP)) u_dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .start(start),
        .step_mode(step_mode), .step(step), .s_inc(s_inc), .s_inm(s_inm),
        .we3(we3), .wez(wez), .Op(Op), .pc_we(pc_we), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    uc_fsm #(.CNT_W(2), .HALT_OP(HALT_OP)) u_sat (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .start(start),
        .step_mode(step_mode), .step(step), .s_inc(s_inc_s), .s_inm(s_inm_s),
        .we3(we3_s), .wez(wez_s), .Op(Op_s), .pc_we(pc_we_s), .halted(halted_s),
        .illegal(illegal_s), .instr_count(instr_count_s)
    );

    // scoreboard
    logic [37:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    // reference model: current and next-cycle view of the controller
    bit          m_started, m_halted, m_stepping, m_illegal, m_prev_step;
    int unsigned m_count;
    bit          n_started, n_halted, n_stepping, n_illegal, n_prev_step;
    int unsigned n_count;

    // 0 = executable, 1 = halt, 2 = illegal
    function automatic int classify(input logic [5:0] op);
        if (op == HALT_OP) return 1;
        if (op[5]) return 0;
        if (op == 6'b000000) return 0;
        if (op[5:2] == 4'b0001) return 0;
        if (op == OP_J || op == OP_JZ || op == OP_JNZ) return 0;
        return 2;
    endfunction

    // {s_inc, s_inm, we3, wez, Op[2:0], pc_we}
    function automatic logic [7:0] ctl(input logic [5:0] op, input logic zz);
        if (op[5]) return {4'b1011, op[4:2], 1'b1};
        if (op == OP_NOP) return 8'b1000_0001;
        if (op[5:2] == 4'b0001) return 8'b1110_0001;
        if (op == OP_J) return 8'b0000_0001;
        if (op == OP_JZ) return {~zz, 7'b000_0001};
        if (op == OP_JNZ) return {zz, 7'b000_0001};
        return 8'h00;
    endfunction

    function automatic logic [37:0] pack_exp(input logic [7:0] c);
        logic [15:0] c16;
        logic [1:0]  c2;
        c16 = 16'(m_count);
        c2  = (m_count > 3) ? 2'd3 : 2'(m_count);
        return {c, m_halted, m_illegal, c16, c, m_halted, m_illegal, c2};
    endfunction

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_stepping = 0; m_illegal = 0; m_prev_step = 0; m_count = 0;
        n_started = 0; n_halted = 0; n_stepping = 0; n_illegal = 0; n_prev_step = 0; n_count = 0;
    endtask

    // driver: one clock cycle of stimulus
    task automatic cycle(input logic [5:0] op, input logic zz, input logic st,
                         input logic sm, input logic stp, input string tag);
        bit         ex;
        int         k;
        logic [7:0] c;
        @(posedge clk); #1;
        m_started = n_started; m_halted = n_halted; m_stepping = n_stepping;
        m_illegal = n_illegal; m_prev_step = n_prev_step; m_count = n_count;
        Opcode = op; z = zz; start = st; step_mode = sm; step = stp;
        ex = m_started && !m_halted && (!m_stepping || (stp && !m_prev_step));
        k  = classify(op);
        c  = (ex && k == 0) ? ctl(op, zz) : 8'h00;
        exp_q.push_back(pack_exp(c));
        tag_q.push_back(tag);
        n_prev_step = stp;
        if (!m_started) begin
            if (st) begin
                n_started  = 1;
                n_stepping = sm;
            end
        end else if (!m_halted) begin
            if (ex && k != 0) begin
                n_halted = 1;
                if (k == 2) n_illegal = 1;
            end else begin
                n_stepping = sm;
            end
        end
        if (c[0]) n_count = (m_count >= 65535) ? 65535 : m_count + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0; Opcode = OP_NOP; z = 1'b0;
        model_reset();
        exp_q.push_back(pack_exp(8'h00));
        tag_q.push_back("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // reset dropped between edges; enables must fall with no clock involved
    task automatic async_reset_check();
        logic [37:0] act;
        @(negedge clk); #2;
        reset = 1'b0; step = 1'b0; start = 1'b0;
        #1;
        act = {s_inc, s_inm, we3, wez, Op, pc_we, halted, illegal, instr_count,
               s_inc_s, s_inm_s, we3_s, wez_s, Op_s, pc_we_s, halted_s, illegal_s, instr_count_s};
        checks++;
        if (act !== 38'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", act, 38'd0);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // monitor
    initial begin
        logic [37:0] exp_v, act;
        string       tag;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = tag_q.pop_front();
                act = {s_inc, s_inm, we3, wez, Op, pc_we, halted, illegal, instr_count,
                       s_inc_s, s_inm_s, we3_s, wez_s, Op_s, pc_we_s, halted_s, illegal_s, instr_count_s};
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", tag, act, exp_v);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        bit         sm_r;
        int         r;
        reset = 1'b0; Opcode = OP_NOP; z = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        model_reset();
        do_reset();

        // free run: ALU, branches, li, nop, j; counter saturation on the 2-bit instance
        cycle(OP_ALU1, 0, 1, 0, 0, "idle_start");
        cycle(OP_ALU1, 0, 0, 0, 0, "alu_op1");
        cycle(OP_JZ,   1, 0, 0, 0, "jz_taken");
        cycle(OP_JZ,   0, 0, 0, 0, "jz_not_taken");
        cycle(OP_JNZ,  1, 0, 0, 0, "jnz_not_taken");
        cycle(OP_JNZ,  0, 0, 0, 0, "jnz_taken");
        cycle(OP_LI,   1, 0, 0, 0, "li");
        cycle(OP_J,    0, 0, 0, 0, "j");
        for (int i = 0; i < 5; i++) cycle(OP_NOP, 0, 0, 0, 0, "nop_sat");
        cycle(6'b111100, 0, 0, 0, 0, "alu_op7");
        cycle(HALT_OP, 0, 0, 0, 0, "halt_op");
        cycle(OP_NOP,  0, 1, 0, 1, "halt_sticky");
        cycle(OP_ALU1, 0, 1, 1, 0, "halt_sticky2");
        do_reset();

        // illegal opcode trap
        cycle(OP_NOP, 0, 1, 0, 0, "idle_start2");
        cycle(OP_LI,  0, 0, 0, 0, "li2");
        cycle(OP_BAD, 0, 0, 0, 0, "illegal_op");
        cycle(OP_NOP, 0, 0, 0, 0, "illegal_sticky");
        do_reset();

        // single-step: held step, pulses, STEP->RUN with an edge, halt beats step_mode
        cycle(OP_NOP, 0, 1, 1, 0, "idle_to_step");
        for (int i = 0; i < 5; i++) cycle(OP_ALU1, 0, 0, 1, 1, "step_held");
        cycle(OP_ALU1, 0, 0, 1, 0, "step_low");
        for (int i = 0; i < 3; i++) begin
            cycle(OP_LI,  0, 0, 1, 1, "step_pulse");
            cycle(OP_LI,  0, 0, 1, 0, "step_gap");
        end
        cycle(HALT_OP, 0, 0, 1, 0, "halt_no_exec");
        cycle(OP_ALU1, 0, 0, 0, 1, "step_to_run_edge");
        cycle(OP_NOP,  0, 0, 0, 1, "run_after_step");
        cycle(OP_NOP,  0, 0, 1, 0, "run_to_step");
        cycle(OP_NOP,  0, 0, 1, 0, "step_idle");
        cycle(HALT_OP, 0, 0, 0, 1, "halt_in_step");
        cycle(OP_NOP,  0, 0, 0, 0, "halted_after_step");
        do_reset();
        cycle(OP_NOP,  0, 1, 0, 0, "idle_start3");
        cycle(OP_BAD,  0, 0, 1, 0, "trap_beats_mode");
        cycle(OP_NOP,  0, 0, 1, 1, "halted_mode");
        do_reset();

        // asynchronous reset mid-instruction
        cycle(OP_NOP,  0, 1, 0, 0, "idle_start4");
        cycle(OP_ALU1, 0, 0, 0, 0, "alu_before_reset");
        async_reset_check();
        cycle(OP_ALU1, 0, 0, 0, 0, "idle_after_async");

        // randomized traffic
        sm_r = 0;
        for (int i = 0; i < 600; i++) begin
            if (n_halted && $urandom_range(0, 3) == 0) do_reset();
            r = $urandom_range(0, 15);
            case (r)
                0, 1, 2, 3, 13, 14: op = {1'b1, 5'($urandom)};
                6:  op = OP_NOP;
                7:  op = {4'b0001, 2'($urandom)};
                8:  op = OP_J;
                9:  op = OP_JZ;
                10: op = OP_JNZ;
                11: op = HALT_OP;
                12: op = 6'($urandom);
                default: op = OP_NOP;
            endcase
            if ($urandom_range(0, 19) == 0) sm_r = ~sm_r;
            cycle(op, 1'($urandom), ($urandom_range(0, 3) == 0), sm_r,
                  ($urandom_range(0, 2) == 0), "random");
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
